// File: rtl/dwconv3x3_stream.sv
// dwconv3x3_stream: streaming 3x3 depthwise convolution (valid, stride 1/2) with two line buffers.
// Ports: clk/rst (async, active-high); start, img_width, img_height, stride2 latched on start;
//   wt_we/wt_addr/wt_data load per-channel kernels (channel*9 + ky*3 + kx) in IDLE only;
//   in_valid/in_ready/in_data raster-order pixel stream, all lanes per beat;
//   out_valid/out_ready/out_data result stream; busy high outside IDLE; done pulses at frame end.
// Build option: define DWCONV_RELU_EN to clamp negative saturated results to zero.
module dwconv3x3_stream #(
  parameter int DATA_WIDTH     = 8,
  parameter int CHANNELS       = 16,
  parameter int MAX_IMAGE_SIZE = 512,
  parameter int SIZE_W         = 10,
  parameter int SHIFT          = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [SIZE_W-1:0]                  img_width,
  input  logic [SIZE_W-1:0]                  img_height,
  input  logic                               stride2,
  input  logic                               wt_we,
  input  logic [$clog2(CHANNELS*9)-1:0]      wt_addr,
  input  logic [DATA_WIDTH-1:0]              wt_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]     in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0]     out_data,
  output logic                               busy,
  output logic                               done
);
  localparam int NW    = CHANNELS * 9;
  localparam int AW    = $clog2(NW);
  localparam int LW    = CHANNELS * DATA_WIDTH;
  localparam int ACC_W = 2 * DATA_WIDTH + 4;
  localparam int LB_AW = $clog2(MAX_IMAGE_SIZE);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                        state;
  logic [SIZE_W-1:0]             w_reg, h_reg, row, col;
  logic                          s2_reg;
  logic signed [DATA_WIDTH-1:0]  wt [NW];
  logic [LW-1:0]                 lb0 [MAX_IMAGE_SIZE];
  logic [LW-1:0]                 lb1 [MAX_IMAGE_SIZE];
  logic [LW-1:0]                 win [3][2];
  logic [LW-1:0]                 taps [3][3];
  logic [LW-1:0]                 result;
  logic [LB_AW-1:0]              ci;
  logic                          acc, last_col, last_pix, produce, start_ok;

  assign ci       = col[LB_AW-1:0];
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign acc      = in_valid && in_ready;
  assign last_col = col == w_reg - 1'b1;
  assign last_pix = last_col && (row == h_reg - 1'b1);
  // stride 2 keeps windows whose top-left corner (r-2, c-2) is even, i.e. r and c even
  assign produce  = row >= SIZE_W'(2) && col >= SIZE_W'(2) && (!s2_reg || (!row[0] && !col[0]));
  assign start_ok = img_width >= SIZE_W'(3) && img_width <= SIZE_W'(MAX_IMAGE_SIZE) &&
                    img_height >= SIZE_W'(3) && img_height <= SIZE_W'(MAX_IMAGE_SIZE);

  // window columns: [0] = c-2, [1] = c-1, [2] = incoming column; rows: [0] = r-2, [1] = r-1, [2] = r
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      taps[k][0] = win[k][0];
      taps[k][1] = win[k][1];
    end
    taps[0][2] = lb1[ci];
    taps[1][2] = lb0[ci];
    taps[2][2] = in_data;
  end

  for (genvar l = 0; l < CHANNELS; l++) begin : g_lane
    logic signed [ACC_W-1:0]      sum, sh;
    logic signed [DATA_WIDTH-1:0] px, sat;
    always_comb begin
      sum = '0;
      px  = '0;
      for (int k = 0; k < 9; k++) begin
        px  = taps[k / 3][k % 3][l*DATA_WIDTH +: DATA_WIDTH];
        sum = sum + ACC_W'(px) * ACC_W'(wt[l*9 + k]);
      end
      sh  = sum >>> SHIFT;
      sat = sh > SAT_HI ? SAT_HI[DATA_WIDTH-1:0] : sh < SAT_LO ? SAT_LO[DATA_WIDTH-1:0] : sh[DATA_WIDTH-1:0];
    end
`ifdef DWCONV_RELU_EN
    assign result[l*DATA_WIDTH +: DATA_WIDTH] = sat[DATA_WIDTH-1] ? '0 : sat;
`else
    assign result[l*DATA_WIDTH +: DATA_WIDTH] = sat;
`endif
  end

  // storage without reset: weights, line buffers and window registers
  always_ff @(posedge clk) begin
    if (wt_we && !rst && state == IDLE && wt_addr < AW'(NW))
      wt[wt_addr] <= wt_data;
    if (acc) begin
      lb0[ci] <= in_data;
      lb1[ci] <= lb0[ci];
      for (int k = 0; k < 3; k++) begin
        win[k][0] <= win[k][1];
        win[k][1] <= taps[k][2];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      row       <= '0;
      col       <= '0;
      w_reg     <= '0;
      h_reg     <= '0;
      s2_reg    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && start_ok) begin
          state  <= RUN;
          busy   <= 1'b1;
          w_reg  <= img_width;
          h_reg  <= img_height;
          s2_reg <= stride2;
          row    <= '0;
          col    <= '0;
        end
        RUN: if (acc && last_pix) state <= DRAIN;
        DRAIN: if (!out_valid || out_ready) begin
          state <= DONE;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
      if (acc) begin
        col <= last_col ? '0 : col + 1'b1;
        row <= last_col ? row + 1'b1 : row;
      end
      if (acc && produce) begin
        out_valid <= 1'b1;
        out_data  <= result;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dwconv3x3_stream.sv
// tb_dwconv3x3_stream: directed vector bench for dwconv3x3_stream (2 lanes, SHIFT=1).
module tb_dwconv3x3_stream;
  localparam int DW = 8, CH = 2, MAXS = 16, SW = 10, SH = 1;

  logic clk = 0, rst = 1, start = 0, stride2 = 0, wt_we = 0, in_valid = 0, out_ready = 1;
  logic [SW-1:0] img_width = '0, img_height = '0;
  logic [4:0] wt_addr = '0;
  logic [DW-1:0] wt_data = '0;
  logic [CH*DW-1:0] in_data = '0, out_data;
  logic in_ready, out_valid, busy, done;

  dwconv3x3_stream #(.DATA_WIDTH(DW), .CHANNELS(CH), .MAX_IMAGE_SIZE(MAXS), .SIZE_W(SW), .SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .start(start), .img_width(img_width), .img_height(img_height),
    .stride2(stride2), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic signed [7:0] q0[$], q1[$];

  typedef struct {int wv0; int wv1; int mode; int pv; int e0; int e1;} vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int relu(input int v);
`ifdef DWCONV_RELU_EN
    return v < 0 ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic load_wts(input int a, input int b, input bit centre);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      wt_we   = 1;
      wt_addr = 5'(k);
      wt_data = (centre && (k % 9) != 4) ? 8'd0 : 8'(k < 9 ? a : b);
    end
    @(negedge clk);
    wt_we = 0;
  endtask

  task automatic run_frame(input int w, input int h, input bit s2, input int mode, input int pv,
                           input bit bp, input bit poke, output int n_out);
    int idx, cyc, pix, bp_err;
    bit seen_done, stalled, accd;
    logic [CH*DW-1:0] held;
    q0.delete();
    q1.delete();
    img_width  = SW'(w);
    img_height = SW'(h);
    stride2    = s2;
    start      = 1;
    @(negedge clk);
    start = 0;
    idx = 0; cyc = 0; bp_err = 0; seen_done = 0; stalled = 0; held = '0;
    while (!seen_done && cyc < 4000) begin
      pix       = mode == 0 ? idx + 1 : mode == 1 ? pv : (idx / w) * w + (idx % w);
      in_valid  = idx < w * h;
      in_data   = {8'(pix), 8'(pix)};
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      wt_we     = poke && cyc == 0;
      wt_addr   = 5'd4;
      wt_data   = 8'd100;
      #1;
      if (done) seen_done = 1;
      if (stalled && (!out_valid || out_data != held)) bp_err++;
      if (out_valid && !out_ready && in_ready) bp_err++;
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (out_valid && out_ready) begin
        q0.push_back(out_data[7:0]);
        q1.push_back(out_data[15:8]);
      end
      accd = in_valid && in_ready;
      @(negedge clk);
      if (accd) idx++;
      cyc++;
    end
    in_valid = 0; wt_we = 0; out_ready = 1;
    chk("frame_done_pulse", int'(seen_done), 1);
    chk("input_beats", idx, w * h);
    chk("stall_rules", bp_err, 0);
    n_out = q0.size();
  endtask

  // centre weight 2 (lane0) / -2 (lane1) with SHIFT=1 reproduces +/- the centre pixel r*w+c
  task automatic check_centre(input int w, input int h, input bit s2, input int n_out);
    int step, nx, ny, k, v;
    step = s2 ? 2 : 1;
    ny = ((h - 3) >> s2) + 1;
    nx = ((w - 3) >> s2) + 1;
    chk($sformatf("count_%0dx%0d_s%0d", w, h, step), n_out, nx * ny);
    for (int i = 0; i < ny; i++)
      for (int j = 0; j < nx; j++) begin
        k = i * nx + j;
        v = (i * step + 1) * w + j * step + 1;
        chk($sformatf("out%0d_lane0_%0dx%0d", k, w, h), k < n_out ? int'(q0[k]) : -999, relu(v));
        chk($sformatf("out%0d_lane1_%0dx%0d", k, w, h), k < n_out ? int'(q1[k]) : -999, relu(-v));
      end
  endtask

  initial begin
    int n, dcount;
    tbl[0] = '{1, 2, 0, 0, 22, 45};
    tbl[1] = '{127, -128, 1, 127, 127, -128};
    tbl[2] = '{127, 0, 1, -128, -128, 0};
    tbl[3] = '{1, -1, 1, 5, 22, -23};
    tbl[4] = '{2, 3, 1, 7, 63, 94};
    tbl[5] = '{-1, 1, 0, 0, -23, 22};
    tbl[6] = '{-3, 4, 1, -3, 40, -54};

    repeat (2) @(negedge clk);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_out_data", int'(out_data), 0);
    rst = 0;
    @(negedge clk);

    img_width = 2; img_height = 5; start = 1;
    @(negedge clk);
    start = 0;
    chk("illegal_w2_busy", int'(busy), 0);
    img_width = 17; img_height = 3; start = 1;
    @(negedge clk);
    start = 0;
    chk("illegal_w17_busy", int'(busy), 0);

    for (int i = 0; i < 7; i++) begin
      load_wts(tbl[i].wv0, tbl[i].wv1, 0);
      run_frame(3, 3, 0, tbl[i].mode, tbl[i].pv, 0, 0, n);
      chk($sformatf("vec%0d_count", i), n, 1);
      chk($sformatf("vec%0d_lane0", i), n > 0 ? int'(q0[0]) : -999, relu(tbl[i].e0));
      chk($sformatf("vec%0d_lane1", i), n > 0 ? int'(q1[0]) : -999, relu(tbl[i].e1));
    end

    load_wts(1, 2, 0);
    run_frame(3, 3, 0, 0, 0, 0, 1, n);
    chk("busy_wt_write_lane0", n > 0 ? int'(q0[0]) : -999, 22);
    chk("busy_wt_write_lane1", n > 0 ? int'(q1[0]) : -999, 45);

    load_wts(2, -2, 1);
    run_frame(5, 5, 1, 2, 0, 0, 0, n);
    check_centre(5, 5, 1, n);
    run_frame(8, 8, 0, 2, 0, 1, 0, n);
    check_centre(8, 8, 0, n);
    run_frame(7, 5, 1, 2, 0, 1, 0, n);
    check_centre(7, 5, 1, n);

    img_width = 8; img_height = 8; stride2 = 0; start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_data = '0; out_ready = 1;
      @(negedge clk);
    end
    in_valid = 0;
    chk("mid_frame_busy_before_rst", int'(busy), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("mid_rst_no_done", dcount, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
